// File: rtl/grid_scope_pkg.sv
// Shared constants and capture state type for the
// oscilloscope-style grid and trace overlay.
package grid_scope_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int DIV_X_DEF = 10;
  localparam int DIV_Y_DEF = 10;
  localparam int COORD_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_HOLD    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/grid_scope_trace_ram.sv
// Per-channel trace store: one write port, one read port,
// reads return the pre-write contents on address collision.
module scope_trace_ram
  import grid_scope_pkg::*;
#(
  parameter int DEPTH = H_RES_DEF,
  parameter int AW    = 10,
  parameter int DW    = COORD_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/grid_scope_trace.sv
// Captures per-channel sample traces and overlays them
// on a divided grid, producing a 2-cycle-latency pixel colour.
module grid_scope_trace
  import grid_scope_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int N_CH  = 2,
  parameter int DIV_X = DIV_X_DEF,
  parameter int DIV_Y = DIV_Y_DEF,
  parameter logic [3*N_CH-1:0] CH_COLOR = {3'b110, 3'b011},
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               video_on,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [2:0]         grid_color,
  input  logic               frame_start,
  input  logic               freeze,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [CHW-1:0]     s_ch,
  input  logic [COORD_W-1:0] s_data,
  output logic [2:0]         graph_rgb
);

  localparam int AW    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int WPW   = $clog2(H_RES + 1);
  localparam int XSTEP = H_RES / DIV_X;
  localparam int YSTEP = V_RES / DIV_Y;
  localparam logic [WPW-1:0]     WP_FULL = WPW'(H_RES);
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_RES - 1);
  localparam logic [COORD_W-1:0] X_LIM   = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] Y_LIM   = COORD_W'(V_RES);

  cap_state_t state, state_nxt;

  logic [WPW-1:0]     wptr     [N_CH];
  logic [WPW-1:0]     wptr_nxt [N_CH];
  logic [N_CH-1:0]    we;
  logic               acc, arm, ch_ok, all_full;
  logic [COORD_W-1:0] wdata;

  assign acc   = s_valid && s_ready;
  assign arm   = frame_start && !freeze && (state != ST_CAPTURE);
  assign ch_ok = {1'b0, s_ch} < (CHW+1)'(N_CH);
  assign wdata = (s_data >= Y_LIM) ? Y_LAST : s_data;

  always_comb begin
    all_full = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      we[c] = acc && ch_ok && (s_ch == CHW'(c))
            && (wptr[c] != WP_FULL);
      wptr_nxt[c] = arm ? '0 : wptr[c] + WPW'(we[c]);
      if (wptr_nxt[c] != WP_FULL) all_full = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_HOLD:
        if (arm) state_nxt = ST_CAPTURE;
      ST_CAPTURE:
        if (all_full) state_nxt = ST_HOLD;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state == ST_CAPTURE);
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (reset) wptr[c] <= '0;
      else       wptr[c] <= wptr_nxt[c];
    end
  end

  // Stage 0: RAM read address and per-channel display qualifier
  logic               x_ok;
  logic [AW-1:0]      raddr;
  logic [N_CH-1:0]    disp0;
  logic [COORD_W-1:0] rdata [N_CH];

  assign x_ok  = pix_x < X_LIM;
  assign raddr = x_ok ? AW'(pix_x) : '0;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      disp0[c] = x_ok && ((state == ST_HOLD)
        || ((state == ST_CAPTURE)
          && (int'(pix_x) < int'(wptr[c]))));
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    scope_trace_ram #(
      .DEPTH (H_RES),
      .AW    (AW),
      .DW    (COORD_W)
    ) u_ram (
      .clk   (clk),
      .we    (we[c]),
      .waddr (AW'(wptr[c])),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata[c])
    );
  end

  logic               von_d1;
  logic [COORD_W-1:0] x_d1, y_d1;
  logic [N_CH-1:0]    disp_d1;

  always_ff @(posedge clk) begin
    if (reset) begin
      von_d1  <= 1'b0;
      x_d1    <= '0;
      y_d1    <= '0;
      disp_d1 <= '0;
    end else begin
      von_d1  <= video_on;
      x_d1    <= pix_x;
      y_d1    <= pix_y;
      disp_d1 <= disp0;
    end
  end

  // Centre lines are dotted along the orthogonal axis
  function automatic logic dot_on(input logic [COORD_W-1:0] v);
    return v[2] || (v <= COORD_W'(1));
  endfunction

  logic       v_on, h_on;
  logic [2:0] pix_nxt;

  always_comb begin
    v_on = (x_d1 == X_LAST);
    h_on = (y_d1 == Y_LAST);
    for (int k = 0; k < DIV_X; k++) begin
      if (x_d1 == COORD_W'(k * XSTEP))
        v_on = v_on | ((k == DIV_X/2) ? dot_on(y_d1) : 1'b1);
    end
    for (int k = 0; k < DIV_Y; k++) begin
      if (y_d1 == COORD_W'(k * YSTEP))
        h_on = h_on | ((k == DIV_Y/2) ? dot_on(x_d1) : 1'b1);
    end
  end

  always_comb begin
    pix_nxt = (v_on || h_on) ? grid_color : 3'b000;
    for (int c = N_CH-1; c >= 0; c--) begin
      if (disp_d1[c] && (rdata[c] == y_d1))
        pix_nxt = CH_COLOR[3*c +: 3];
    end
    if (!von_d1) pix_nxt = 3'b000;
  end

  always_ff @(posedge clk) begin
    if (reset) graph_rgb <= 3'b000;
    else       graph_rgb <= pix_nxt;
  end

endmodule

// File: tb/tb_grid_scope_trace.sv
// Directed bench for grid_scope_trace: capture, display,
// clamping, discard, freeze and reset behaviour.
module tb_grid_scope_trace;

  logic       clk = 1'b0;
  logic       reset;
  logic       video_on;
  logic [9:0] pix_x, pix_y;
  logic [2:0] grid_color;
  logic       frame_start, freeze;
  logic       s_valid, s_ready;
  logic [0:0] s_ch;
  logic [9:0] s_data;
  logic [2:0] graph_rgb;

  logic       s3_valid, s3_ready;
  logic [1:0] s3_ch;
  logic [9:0] s3_data;
  logic [2:0] rgb3;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_miss = 0;

  always #5 clk = ~clk;

  grid_scope_trace dut (
    .clk         (clk),
    .reset       (reset),
    .video_on    (video_on),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .grid_color  (grid_color),
    .frame_start (frame_start),
    .freeze      (freeze),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_ch        (s_ch),
    .s_data      (s_data),
    .graph_rgb   (graph_rgb)
  );

  grid_scope_trace #(
    .H_RES    (16),
    .V_RES    (16),
    .N_CH     (3),
    .DIV_X    (4),
    .DIV_Y    (4),
    .CH_COLOR ({3'b001, 3'b110, 3'b011})
  ) dut3 (
    .clk         (clk),
    .reset       (reset),
    .video_on    (video_on),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .grid_color  (grid_color),
    .frame_start (frame_start),
    .freeze      (freeze),
    .s_valid     (s3_valid),
    .s_ready     (s3_ready),
    .s_ch        (s3_ch),
    .s_data      (s3_data),
    .graph_rgb   (rgb3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int ch, input int d);
    s_ch    = 1'(ch);
    s_data  = 10'(d);
    s_valid = 1'b1;
    if (!s_ready) hs_miss++;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send3(input int ch, input int d);
    s3_ch    = 2'(ch);
    s3_data  = 10'(d);
    s3_valid = 1'b1;
    tick();
    s3_valid = 1'b0;
  endtask

  // Output is sampled two edges after the pixel is presented;
  // video_on drops after the first edge to pin the latency.
  task automatic probe(input int x, input int y, input logic von);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = von;
    tick();
    video_on = 1'b0;
    tick();
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  localparam logic [2:0] GC = 3'b101;
  localparam logic [2:0] C0 = 3'b011;
  localparam logic [2:0] C1 = 3'b110;

  initial begin
    reset = 1'b1; video_on = 1'b1;
    pix_x = 10'd100; pix_y = 10'd50;
    grid_color = GC; frame_start = 1'b0; freeze = 1'b0;
    s_valid = 1'b0; s_ch = '0; s_data = '0;
    s3_valid = 1'b0; s3_ch = '0; s3_data = '0;

    repeat (3) tick();
    chk("rst_rgb", 16'(graph_rgb), 16'd0);
    chk("rst_ready", 16'(s_ready), 16'd0);
    reset = 1'b0;
    tick();
    chk("idle_ready", 16'(s_ready), 16'd0);
    probe(128, 50, 1'b1);
    chk("idle_grid", 16'(graph_rgb), 16'(GC));

    pulse_fs();
    chk("cap_ready", 16'(s_ready), 16'd1);
    for (int x = 0; x < 10; x++) send(0, 5);
    chk("hs_part", 16'(hs_miss), 16'd0);
    for (int x = 0; x < 70; x++) begin
      probe(x, 5, 1'b1);
      chk("row5", 16'(graph_rgb),
          16'((x < 10) ? C0 : (x == 64) ? GC : 3'b000));
    end
    pulse_fs();
    probe(3, 5, 1'b1);
    chk("cap_fs_ignored", 16'(graph_rgb), 16'(C0));
    for (int x = 10; x < 300; x++) send(0, x / 2);

    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_mid_ready", 16'(s_ready), 16'd0);
    probe(100, 50, 1'b1);
    chk("rst_blank", 16'(graph_rgb), 16'd0);
    probe(320, 3, 1'b1);
    chk("vdot_off", 16'(graph_rgb), 16'd0);
    probe(320, 4, 1'b1);
    chk("vdot_on", 16'(graph_rgb), 16'(GC));
    probe(2, 240, 1'b1);
    chk("hdot_off", 16'(graph_rgb), 16'd0);
    probe(4, 240, 1'b1);
    chk("hdot_on", 16'(graph_rgb), 16'(GC));
    chk("no_rearm", 16'(s_ready), 16'd0);

    pulse_fs();
    for (int x = 0; x < 640; x++) send(0, x / 2);
    for (int x = 0; x < 639; x++) send(1, (x == 200) ? 700 : 479);
    frame_start = 1'b1;
    send(1, 479);
    frame_start = 1'b0;
    chk("hold_ready", 16'(s_ready), 16'd0);
    chk("hs_full", 16'(hs_miss), 16'd0);
    probe(100, 50, 1'b1);
    chk("ch0_px", 16'(graph_rgb), 16'(C0));
    probe(100, 479, 1'b1);
    chk("ch1_px", 16'(graph_rgb), 16'(C1));
    probe(200, 479, 1'b1);
    chk("clamp_px", 16'(graph_rgb), 16'(C1));
    probe(639, 479, 1'b1);
    chk("last_px", 16'(graph_rgb), 16'(C1));
    probe(639, 319, 1'b1);
    chk("ch0_last", 16'(graph_rgb), 16'(C0));
    probe(100, 51, 1'b1);
    chk("off_trace", 16'(graph_rgb), 16'd0);
    probe(100, 50, 1'b0);
    chk("video_off", 16'(graph_rgb), 16'd0);
    probe(700, 350, 1'b1);
    chk("x_beyond", 16'(graph_rgb), 16'd0);

    freeze = 1'b1;
    pulse_fs();
    chk("freeze_ready", 16'(s_ready), 16'd0);
    probe(100, 50, 1'b1);
    chk("freeze_hold", 16'(graph_rgb), 16'(C0));
    freeze = 1'b0;
    pulse_fs();
    chk("rearm_ready", 16'(s_ready), 16'd1);
    probe(100, 50, 1'b1);
    chk("rearm_blank", 16'(graph_rgb), 16'd0);

    chk("d3_ready", 16'(s3_ready), 16'd1);
    send3(3, 7);
    probe(0, 7, 1'b1);
    chk("d3_discard", 16'(rgb3), 16'(GC));
    send3(0, 7);
    probe(0, 7, 1'b1);
    chk("d3_write", 16'(rgb3), 16'(C0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
